word_assembler: RTL
===================

WORD_ASSEMBLER -- requirements
Module: word_assembler

Interface
REQ-001 Parameter BYTE_W, default 8, width of BUS and of each captured byte.
REQ-002 Word width SHALL be 2*BYTE_W, 16 at default.
REQ-003 CLK  input  1  sole clock; all state SHALL change on posedge CLK only.
REQ-004 RST_N  input  1  reset, synchronous and active-low.
REQ-005 BUS  input  BYTE_W  shared data bus, sampled at posedge CLK.
REQ-006 LD_L  input  1  capture BUS into low byte.
REQ-007 LD_H  input  1  capture BUS into high byte.
REQ-008 INC  input  1  increment held word by 1.
REQ-009 WORD_RDY  input  1  consumer accepts WORD this cycle.
REQ-010 WORD  output  2*BYTE_W  assembled word {high, low}, registered.
REQ-011 WORD_VLD  output  1  WORD complete and unconsumed, registered.
REQ-012 ERR  output  1  one-cycle pulse flagging a load while full, registered.

Function
REQ-013 FSM states SHALL be EMPTY, HAVE_L, HAVE_H and FULL.
REQ-014 EMPTY: LD_L only -> HAVE_L; LD_H only -> HAVE_H; LD_L and LD_H together -> FULL, with both bytes taken from the same BUS value.
REQ-015 HAVE_L: LD_H -> FULL; LD_L alone SHALL overwrite the low byte, stay in HAVE_L, no ERR.
REQ-016 HAVE_H: LD_L -> FULL; LD_H alone SHALL overwrite the high byte, stay in HAVE_H, no ERR.
REQ-017 In HAVE_L or HAVE_H, LD_L and LD_H together SHALL load both bytes from BUS -> FULL.
REQ-018 WORD_VLD SHALL equal 1 exactly when the state is FULL; it rises the cycle after the edge completing the word, so latency is 1 clock.
REQ-019 FULL with WORD_VLD=1 and WORD_RDY=1 -> transfer, next state EMPTY; WORD SHALL hold its value, with WORD_VLD deasserted.
REQ-020 FULL with INC=1 and no transfer: WORD <= WORD+1 modulo 2^(2*BYTE_W), with 0xFFFF wrapping to 0x0000; state stays FULL.
REQ-021 Transfer and INC in the same cycle: transfer SHALL win and INC is ignored.
REQ-022 INC in any state other than FULL SHALL be ignored.
REQ-023 LD_L or LD_H in FULL without a transfer: word unchanged, ERR=1 for the following cycle only.
REQ-024 LD_L or LD_H in FULL with a transfer in the same cycle: the load SHALL be accepted as if the state were EMPTY (REQ-014), no ERR.
REQ-025 In HAVE_L or HAVE_H, the uncaptured half of WORD SHALL keep its previous value.
REQ-026 WORD_RDY without WORD_VLD SHALL have no effect.

Reset
REQ-027 RST_N=0 at posedge CLK: state EMPTY, WORD=0, WORD_VLD=0, ERR=0.
REQ-028 Reset SHALL override every other input in the same cycle.
REQ-029 Reset mid-assembly (HAVE_L, HAVE_H or FULL) SHALL discard the partial or unconsumed word.
REQ-030 The first load SHALL be accepted on the first edge with RST_N=1.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding (2-bit, EMPTY=00) and the BYTE_W default.
REQ-032 The block SHALL be one module with no sub-modules; the incrementer and byte registers are inline.

Verification
REQ-033 Reset, then BUS=0x34 with LD_L, then BUS=0x12 with LD_H, WORD_RDY=0 -> WORD=0x1234, WORD_VLD=1 one cycle after the LD_H edge, held until consumed.
REQ-034 BUS=0xAB with LD_L and LD_H in the same cycle -> WORD=0xABAB, WORD_VLD=1 next cycle.
REQ-035 FULL with WORD=0xFFFF, INC=1 for 2 cycles -> 0x0000, then 0x0001; WORD_VLD stays 1.
REQ-036 FULL with LD_H=1, WORD_RDY=0 -> ERR=1 for exactly one cycle, WORD unchanged.
REQ-036a Repeat with WORD_RDY=1 and BUS=0x55 -> state HAVE_H, no ERR.
REQ-037 FULL with INC=1 and WORD_RDY=1 together -> WORD_VLD=0 next cycle, WORD not incremented.
REQ-038 HAVE_L after loading 0x34, then RST_N=0 for one cycle -> WORD=0, WORD_VLD=0; a following LD_H alone SHALL NOT raise WORD_VLD.

Source files
------------

// File: rtl/word_assembler_pkg.sv
// Shared definitions for the byte-to-word assembler.
// Holds the FSM state encoding and the default byte width.
package word_assembler_pkg;

    // Default width of the bus and of each captured byte
    localparam int BYTE_W_DEF = 8;

    // Assembly progress; EMPTY must stay 2'b00 so reset clears to it
    typedef enum logic [1:0] {
        EMPTY  = 2'b00,
        HAVE_L = 2'b01,
        HAVE_H = 2'b10,
        FULL   = 2'b11
    } state_t;

endpackage

// File: rtl/word_assembler.sv
// Assembles two bytes from a shared bus into one word with a
// valid/ready output, in-place increment and an overload flag.
module word_assembler
    import word_assembler_pkg::*;
#(
    parameter int BYTE_W = BYTE_W_DEF
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [BYTE_W-1:0]   BUS,
    input  logic                LD_L,
    input  logic                LD_H,
    input  logic                INC,
    input  logic                WORD_RDY,
    output logic [2*BYTE_W-1:0] WORD,
    output logic                WORD_VLD,
    output logic                ERR
);

    localparam int WW = 2 * BYTE_W;

    state_t          state_q;
    state_t          state_d;
    logic [WW-1:0]   word_q;
    logic [WW-1:0]   word_d;
    logic            err_q;
    logic            err_d;
    logic            xfer;

    // A transfer can only happen while a complete word is held
    assign xfer = (state_q == FULL) && WORD_RDY;

    // State, word and error registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= EMPTY;
            word_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            err_q   <= err_d;
        end
    end

    // Next-state, byte capture, increment and error decode
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        err_d   = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (LD_L) word_d[BYTE_W-1:0]  = BUS;
                if (LD_H) word_d[WW-1:BYTE_W] = BUS;
                unique case ({LD_H, LD_L})
                    2'b00: state_d = EMPTY;
                    2'b01: state_d = HAVE_L;
                    2'b10: state_d = HAVE_H;
                    2'b11: state_d = FULL;
                endcase
            end
            HAVE_L: begin
                if (LD_L) word_d[BYTE_W-1:0]  = BUS;
                if (LD_H) begin
                    word_d[WW-1:BYTE_W] = BUS;
                    state_d = FULL;
                end
            end
            HAVE_H: begin
                if (LD_H) word_d[WW-1:BYTE_W] = BUS;
                if (LD_L) begin
                    word_d[BYTE_W-1:0] = BUS;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (xfer) begin
                    // Consumed word frees the slot; a same-cycle
                    // load is taken as if starting from EMPTY
                    if (LD_L) word_d[BYTE_W-1:0]  = BUS;
                    if (LD_H) word_d[WW-1:BYTE_W] = BUS;
                    unique case ({LD_H, LD_L})
                        2'b00: state_d = EMPTY;
                        2'b01: state_d = HAVE_L;
                        2'b10: state_d = HAVE_H;
                        2'b11: state_d = FULL;
                    endcase
                end else if (LD_L || LD_H) begin
                    // Load into an occupied slot is rejected
                    err_d = 1'b1;
                end else if (INC) begin
                    word_d = word_q + WW'(1);
                end
            end
        endcase
    end

    assign WORD     = word_q;
    assign WORD_VLD = (state_q == FULL);
    assign ERR      = err_q;

endmodule
